v_chunk_server: RTL and testbench

- Responder side of the mlop chunk interface. Feeds vector operators such as the leaky-ReLU stage, which raise a chunk request each time they consume one.
- Accepts a scalar element stream (valid/ready), assembles whole vectors into a ping-pong register buffer, and presents each vector as WorkingRegs-wide chunks.
- Advances one chunk per request, so a vector op sees single-cycle-FIFO semantics.
- Sits between an upstream element source and the first mlop of a pipeline.

---
 rtl/v_chunk_server_pkg.sv | 15 +
 rtl/v_chunk_server_bank.sv | 43 ++++
 rtl/v_chunk_server.sv | 129 ++++++++++++
 tb/tb_v_chunk_server.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_chunk_server_pkg.sv
// Shared mlop definitions used by the chunk server and the vector operators.
//   chunk_t   : one chunk of MLOP_WORKING_REGS signed lanes, lane 0 in the low bits.
//   n_chunks  : number of chunks needed to cover a vector (ceiling division).
package v_chunk_server_pkg;

  localparam int MLOP_NBITS        = 8;
  localparam int MLOP_WORKING_REGS = 4;

  typedef logic signed [MLOP_WORKING_REGS-1:0][MLOP_NBITS-1:0] chunk_t;

  function automatic int n_chunks(input int vec_len, input int work_regs);
    return (vec_len + work_regs - 1) / work_regs;
  endfunction

endpackage

// File: rtl/v_chunk_server_bank.sv
// One vector bank of the chunk server.
//   clk_in      : clock
//   i_we        : write enable for element i_idx
//   i_idx       : element index to write
//   i_data      : element value
//   i_chunk_idx : chunk selected on the read port
//   o_chunk     : combinational chunk read; lanes past the vector end read 0
// Contents are never reset: they are only visible once a full flag says so.
module v_chunk_server_bank
  import v_chunk_server_pkg::*;
#(
  parameter int VecLength   = 16,
  parameter int NBits       = 8,
  parameter int WorkingRegs = 4,
  parameter int IDX_W       = 4,
  parameter int CI_W        = 2
) (
  input  logic                                     clk_in,
  input  logic                                     i_we,
  input  logic [IDX_W-1:0]                         i_idx,
  input  logic signed [NBits-1:0]                  i_data,
  input  logic [CI_W-1:0]                          i_chunk_idx,
  output logic signed [WorkingRegs-1:0][NBits-1:0] o_chunk
);

  logic signed [NBits-1:0] r_mem [VecLength];
  int                      w_elem;

  always_ff @(posedge clk_in) begin
    if (i_we) r_mem[i_idx] <= i_data;
  end

  // Element index of each lane; lanes beyond the vector are zero padding.
  always_comb begin
    o_chunk = '0;
    w_elem  = 0;
    for (int i = 0; i < WorkingRegs; i++) begin
      w_elem = int'(i_chunk_idx) * WorkingRegs + i;
      if (w_elem < VecLength) o_chunk[i] = r_mem[w_elem[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/v_chunk_server.sv
// Chunk server: assembles a scalar element stream into whole vectors held in a
// ping-pong pair of banks, and serves each full vector as WorkingRegs-wide
// chunks, advancing one chunk per consumer request.
//   clk_in          : clock
//   rst_in          : asynchronous active-high reset
//   in_valid/in_data/in_ready : upstream element handshake
//   out_data        : current chunk (0 when no full vector is available)
//   out_data_ready  : a full vector is available on the read bank
//   req_chunk       : consumer took out_data this cycle
//   out_first_chunk : current chunk is the first of its vector
//   out_last_chunk  : current chunk is the last of its vector
//   underflow_err   : sticky, request seen with no vector available
module v_chunk_server
  import v_chunk_server_pkg::*;
#(
  parameter int VecLength   = 16,
  parameter int NBits       = 8,
  parameter int WorkingRegs = 4
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     in_valid,
  input  logic signed [NBits-1:0]                  in_data,
  output logic                                     in_ready,
  output logic signed [WorkingRegs-1:0][NBits-1:0] out_data,
  output logic                                     out_data_ready,
  input  logic                                     req_chunk,
  output logic                                     out_first_chunk,
  output logic                                     out_last_chunk,
  output logic                                     underflow_err
);

  localparam int NChunks = n_chunks(VecLength, WorkingRegs);
  localparam int IDX_W   = (VecLength > 1) ? $clog2(VecLength) : 1;
  localparam int CI_W    = (NChunks > 1) ? $clog2(NChunks) : 1;

  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [CI_W-1:0]  r_chunk_idx;
  logic             r_underflow;

  logic [1:0]       w_full_nxt;
  logic             w_accept;
  logic             w_consume;
  logic             w_wr_last;
  logic             w_rd_last;
  logic signed [WorkingRegs-1:0][NBits-1:0] w_chunk0;
  logic signed [WorkingRegs-1:0][NBits-1:0] w_chunk1;

  assign in_ready        = !r_full[r_wr_bank];
  assign out_data_ready  = r_full[r_rd_bank];
  assign w_accept        = in_valid && in_ready;
  assign w_consume       = req_chunk && out_data_ready;
  assign w_wr_last       = (r_wr_idx == IDX_W'(VecLength - 1));
  assign w_rd_last       = (r_chunk_idx == CI_W'(NChunks - 1));
  assign out_first_chunk = out_data_ready && (r_chunk_idx == '0);
  assign out_last_chunk  = out_data_ready && w_rd_last;
  assign underflow_err   = r_underflow;

  v_chunk_server_bank #(
    .VecLength(VecLength), .NBits(NBits), .WorkingRegs(WorkingRegs),
    .IDX_W(IDX_W), .CI_W(CI_W)
  ) u_bank0 (
    .clk_in     (clk_in),
    .i_we       (w_accept && !r_wr_bank),
    .i_idx      (r_wr_idx),
    .i_data     (in_data),
    .i_chunk_idx(r_chunk_idx),
    .o_chunk    (w_chunk0)
  );

  v_chunk_server_bank #(
    .VecLength(VecLength), .NBits(NBits), .WorkingRegs(WorkingRegs),
    .IDX_W(IDX_W), .CI_W(CI_W)
  ) u_bank1 (
    .clk_in     (clk_in),
    .i_we       (w_accept && r_wr_bank),
    .i_idx      (r_wr_idx),
    .i_data     (in_data),
    .i_chunk_idx(r_chunk_idx),
    .o_chunk    (w_chunk1)
  );

  always_comb begin
    out_data = '0;
    if (out_data_ready) out_data = r_rd_bank ? w_chunk1 : w_chunk0;
  end

  // The write side only ever fills a non-full bank and the read side only
  // releases a full one, so a set and a clear never hit the same flag.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_consume && w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_chunk_idx <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_consume) begin
        if (w_rd_last) begin
          r_chunk_idx <= '0;
          r_rd_bank   <= ~r_rd_bank;
        end else begin
          r_chunk_idx <= r_chunk_idx + 1'b1;
        end
      end
      if (req_chunk && !out_data_ready) r_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_v_chunk_server.sv
module tb_v_chunk_server;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  // DUT A: VecLength=10, WorkingRegs=4 (three chunks, last one padded)
  logic              in_valid_a = 1'b0;
  logic signed [7:0] in_data_a  = '0;
  logic              in_ready_a;
  logic signed [3:0][7:0] out_data_a;
  logic              out_data_ready_a;
  logic              req_a = 1'b0;
  logic              first_a, last_a, uf_a;

  // DUT B: VecLength=3, WorkingRegs=4 (single chunk)
  logic              in_valid_b = 1'b0;
  logic signed [7:0] in_data_b  = '0;
  logic              in_ready_b;
  logic signed [3:0][7:0] out_data_b;
  logic              out_data_ready_b;
  logic              req_b = 1'b0;
  logic              first_b, last_b, uf_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  v_chunk_server #(.VecLength(10), .NBits(8), .WorkingRegs(4)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_data_ready(out_data_ready_a),
    .req_chunk(req_a), .out_first_chunk(first_a), .out_last_chunk(last_a),
    .underflow_err(uf_a)
  );

  v_chunk_server #(.VecLength(3), .NBits(8), .WorkingRegs(4)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_data_ready(out_data_ready_b),
    .req_chunk(req_b), .out_first_chunk(first_b), .out_last_chunk(last_b),
    .underflow_err(uf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Lane 0 sits in the low byte.
  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present one element and hold it until accepted (bounded wait).
  task automatic push(input bit sel, input int v);
    int w;
    w = 0;
    if (sel) begin in_valid_b = 1'b1; in_data_b = 8'(v); end
    else     begin in_valid_a = 1'b1; in_data_a = 8'(v); end
    @(negedge clk_in);
    while (!(sel ? in_ready_b : in_ready_a) && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    if (w >= 50) check("push_timeout", 32'(v), 32'hFFFF_FFFF);
    step();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  logic [31:0] exp_chunks [6];
  int          nxt;
  logic        acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready_a), 1);
    check("rst_out_ready", 32'(out_data_ready_a), 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_underflow", 32'(uf_a), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();

    // Single vector 1..10, then one request per cycle
    for (int k = 1; k <= 9; k++) push(1'b0, k);
    check("ready_before_last", 32'(out_data_ready_a), 0);
    push(1'b0, 10);
    @(negedge clk_in);
    check("ready_after_last", 32'(out_data_ready_a), 1);
    check("v1_chunk0", out_data_a, pk(1, 2, 3, 4));
    check("v1_first0", 32'(first_a), 1);
    check("v1_last0", 32'(last_a), 0);
    req_a = 1'b1;
    step();
    @(negedge clk_in);
    check("v1_chunk1", out_data_a, pk(5, 6, 7, 8));
    check("v1_first1", 32'(first_a), 0);
    step();
    @(negedge clk_in);
    check("v1_chunk2", out_data_a, pk(9, 10, 0, 0));
    check("v1_last2", 32'(last_a), 1);
    step();
    req_a = 1'b0;
    @(negedge clk_in);
    check("v1_ready_fall", 32'(out_data_ready_a), 0);
    check("v1_data_zero", out_data_a, 0);
    check("v1_no_underflow", 32'(uf_a), 0);
    step();

    // Request while empty
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    @(negedge clk_in);
    check("uf_set", 32'(uf_a), 1);
    check("uf_ready", 32'(out_data_ready_a), 0);
    check("uf_in_ready", 32'(in_ready_a), 1);
    step();

    // Fill both banks, then drain continuously while refilling the freed bank
    for (int k = 1; k <= 20; k++) push(1'b0, k);
    check("full_in_ready", 32'(in_ready_a), 0);
    check("full_chunk0", out_data_a, pk(1, 2, 3, 4));
    exp_chunks[0] = pk(1, 2, 3, 4);
    exp_chunks[1] = pk(5, 6, 7, 8);
    exp_chunks[2] = pk(9, 10, 0, 0);
    exp_chunks[3] = pk(11, 12, 13, 14);
    exp_chunks[4] = pk(15, 16, 17, 18);
    exp_chunks[5] = pk(19, 20, 0, 0);
    nxt = 21;
    req_a = 1'b1;
    in_valid_a = 1'b1;
    in_data_a = 8'(nxt);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      check($sformatf("b2b_chunk%0d", c), out_data_a, exp_chunks[c]);
      check($sformatf("b2b_in_ready%0d", c), 32'(in_ready_a), (c >= 3) ? 1 : 0);
      check($sformatf("b2b_ready%0d", c), 32'(out_data_ready_a), 1);
      acc = in_ready_a;
      step();
      if (acc) begin
        nxt++;
        in_data_a = 8'(nxt);
      end
    end
    req_a = 1'b0;
    in_valid_a = 1'b0;
    check("b2b_accepted", 32'(nxt), 24);
    @(negedge clk_in);
    check("b2b_drained", 32'(out_data_ready_a), 0);
    step();
    for (int k = 24; k <= 30; k++) push(1'b0, k);
    @(negedge clk_in);
    check("c_chunk0", out_data_a, pk(21, 22, 23, 24));
    req_a = 1'b1;
    step();
    @(negedge clk_in);
    check("c_chunk1", out_data_a, pk(25, 26, 27, 28));
    step();
    @(negedge clk_in);
    check("c_chunk2", out_data_a, pk(29, 30, 0, 0));
    step();
    req_a = 1'b0;
    @(negedge clk_in);
    check("c_empty", 32'(out_data_ready_a), 0);
    check("uf_sticky", 32'(uf_a), 1);
    step();

    // Asynchronous reset mid-stream with one bank full
    for (int k = 1; k <= 14; k++) push(1'b0, k);
    check("pre_rst_ready", 32'(out_data_ready_a), 1);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_ready", 32'(out_data_ready_a), 0);
    check("arst_in_ready", 32'(in_ready_a), 1);
    check("arst_data", out_data_a, 0);
    check("arst_underflow", 32'(uf_a), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    for (int k = 41; k <= 50; k++) push(1'b0, k);
    @(negedge clk_in);
    check("post_rst_chunk0", out_data_a, pk(41, 42, 43, 44));
    check("post_rst_first", 32'(first_a), 1);
    step();

    // Short vector: single padded chunk
    push(1'b1, 5);
    push(1'b1, -2);
    check("short_ready_before", 32'(out_data_ready_b), 0);
    push(1'b1, 7);
    @(negedge clk_in);
    check("short_ready", 32'(out_data_ready_b), 1);
    check("short_chunk", out_data_b, pk(5, -2, 7, 0));
    check("short_first", 32'(first_b), 1);
    check("short_last", 32'(last_b), 1);
    req_b = 1'b1;
    step();
    req_b = 1'b0;
    @(negedge clk_in);
    check("short_released", 32'(out_data_ready_b), 0);
    check("short_in_ready", 32'(in_ready_b), 1);
    check("short_underflow", 32'(uf_b), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
